counter_seq_checker: RTL and testbench
======================================

Name: counter_seq_checker

Overview:
Receive side of the free-running counter output. Samples a WIDTH-bit counter value stream under a valid qualifier and confirms that each sample is the previous sample plus one, modulo 2^WIDTH. It locks onto the sequence, separates counter restarts (a jump to 0) from real sequence errors, counts errors, and captures the first failing pair for debug. Used in benches and on-chip as a health monitor next to any counter instance.

Parameters:
WIDTH, 16, width of the checked counter value
ERR_CNT_WIDTH, 8, width of the saturating error counter
LOCK_COUNT, 4, number of consecutive in-sequence samples needed to reach LOCKED; legal range 1..255

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_data holds a sample this cycle
in_data  input  WIDTH  sampled counter value
clear  input  1  synchronous clear of err_count, the first-error capture and sticky flags; state machine unaffected
locked  output  1  high while state is LOCKED
err_pulse  output  1  one-cycle pulse for each sequence error detected in LOCKED
restart_pulse  output  1  one-cycle pulse when LOCKED sees in_data==0 out of sequence
err_count  output  ERR_CNT_WIDTH  number of errors; saturates at all-ones
first_err_valid  output  1  sticky; first_exp and first_got are valid
first_exp  output  WIDTH  expected value at the first error
first_got  output  WIDTH  received value at the first error

Behaviour:
- Reset values: state SEEK, all outputs 0, expected 0, good_cnt 0.
- Cycles with in_valid=0 change nothing. Gaps between samples are allowed, and the checker compares against the last valid sample.
- expected is always updated to in_data+1 (mod 2^WIDTH) on every valid sample, in every state.
- Outputs are registered. The pulses and the updates to locked, err_count and capture appear in the cycle after the in_valid cycle that caused them.
- Wrap rule: a sample of all-ones followed by 0 is a match. It is neither a restart nor an error.

State machine:
- SEEK: the first valid sample sets good_cnt=1. If LOCK_COUNT==1, go to LOCKED; otherwise go to ACQUIRE. No pulses.
- ACQUIRE:
  - Match: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED.
  - Mismatch: good_cnt=1 and stay in ACQUIRE. This is a silent resync with no error.
- LOCKED:
  - Match: stay in LOCKED.
  - Mismatch with in_data==0: restart_pulse, good_cnt=1, go to ACQUIRE (or stay LOCKED if LOCK_COUNT==1). No error is counted.
  - Mismatch with in_data!=0: err_pulse, err_count += 1 (saturating), good_cnt=1, go to ACQUIRE (or stay LOCKED if LOCK_COUNT==1).
    - If first_err_valid=0: capture first_exp=expected and first_got=in_data, then set first_err_valid.
- locked deasserts in the cycle after the mismatch that leaves LOCKED.

Clear and simultaneous events:
- clear zeroes err_count, first_err_valid, first_exp and first_got.
- clear in the same cycle as an error: clear applies first, then the error. Result is err_count=1 and a fresh capture of the new error.
- At saturation, err_count holds all-ones; err_pulse still fires.
- rst mid-operation returns to SEEK with reset values regardless of in_valid or clear. rst has priority over everything.

Test Plan:
- Reset, then valid samples 5,6,7,8 with LOCK_COUNT=4 -> locked=1 in the cycle after sample 8; no pulses; err_count=0.
- Locked stream 0xFFFE,0xFFFF,0x0000,0x0001 -> no err_pulse, no restart_pulse; locked stays 1.
- Locked at 0x0010, then sample 0x0000 -> restart_pulse once; locked=0. Then 1,2,3 -> locked=1 again; err_count=0.
- Locked at 0x0020, then 0x0025, re-lock, then 0x0099 -> err_count=2; first_exp=0x0021, first_got=0x0025; first_err_valid=1.
- Assert clear in the same cycle as an error sample 0x0050 (expected 0x0031) -> err_count=1; first_exp=0x0031, first_got=0x0050.
- ERR_CNT_WIDTH=2 with 5 errors -> err_count stays 3; 5 err_pulses seen. Assert rst mid-stream -> all outputs 0, state SEEK; the next 4 good samples relock.

Source files
------------

// File: rtl/counter_seq_checker.sv
// counter_seq_checker: locks onto an incrementing counter stream, flags restarts and sequence errors
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid, in_data sample qualifier and sampled counter value
//   clear             zeroes err_count, first-error capture and sticky flag
//   locked            state is LOCKED
//   err_pulse         one-cycle pulse per sequence error seen while LOCKED
//   restart_pulse     one-cycle pulse when LOCKED sees an out-of-sequence 0
//   err_count         saturating error count
//   first_err_valid   sticky; first_exp/first_got hold the first failing pair
module counter_seq_checker #(
    parameter int WIDTH         = 16,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int LOCK_COUNT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     clear,
    output logic                     locked,
    output logic                     err_pulse,
    output logic                     restart_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     first_err_valid,
    output logic [WIDTH-1:0]         first_exp,
    output logic [WIDTH-1:0]         first_got
);
    typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} state_t;

    localparam logic [7:0] LC = 8'(LOCK_COUNT);
    localparam state_t RELOCK = (LC == 8'd1) ? LOCKED : ACQUIRE;

    state_t                   state, state_nx;
    logic [7:0]               good_cnt, good_nx;
    logic [WIDTH-1:0]         expected, exp_nx, fe_nx, fg_nx;
    logic [ERR_CNT_WIDTH-1:0] cnt_nx;
    logic                     ep_nx, rp_nx, fv_nx, match;

    assign locked = state == LOCKED;
    assign match  = in_data == expected;

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        exp_nx   = expected;
        ep_nx    = 1'b0;
        rp_nx    = 1'b0;
        // clear acts before any error found in the same cycle
        cnt_nx   = clear ? '0 : err_count;
        fv_nx    = clear ? 1'b0 : first_err_valid;
        fe_nx    = clear ? '0 : first_exp;
        fg_nx    = clear ? '0 : first_got;
        if (in_valid) begin
            exp_nx = in_data + 1'b1;
            case (state)
                SEEK: begin
                    good_nx  = 8'd1;
                    state_nx = RELOCK;
                end
                ACQUIRE: begin
                    good_nx  = match ? good_cnt + 8'd1 : 8'd1;
                    state_nx = (match && good_cnt + 8'd1 >= LC) ? LOCKED : ACQUIRE;
                end
                LOCKED: if (!match) begin
                    good_nx  = 8'd1;
                    state_nx = RELOCK;
                    rp_nx    = in_data == '0;
                    ep_nx    = in_data != '0;
                    if (ep_nx) begin
                        cnt_nx = &cnt_nx ? cnt_nx : cnt_nx + 1'b1;
                        if (!fv_nx) begin
                            fv_nx = 1'b1;
                            fe_nx = expected;
                            fg_nx = in_data;
                        end
                    end
                end
                default: state_nx = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SEEK;
            good_cnt        <= '0;
            expected        <= '0;
            err_pulse       <= 1'b0;
            restart_pulse   <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_exp       <= '0;
            first_got       <= '0;
        end else begin
            state           <= state_nx;
            good_cnt        <= good_nx;
            expected        <= exp_nx;
            err_pulse       <= ep_nx;
            restart_pulse   <= rp_nx;
            err_count       <= cnt_nx;
            first_err_valid <= fv_nx;
            first_exp       <= fe_nx;
            first_got       <= fg_nx;
        end
    end
endmodule

// File: tb/tb_counter_seq_checker.sv
// tb_counter_seq_checker: table vectors, corner sequences and random stream against a reference model
module tb_counter_seq_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] in_data = '0;

    logic        lk1, ep1, rp1, fv1, lk2, ep2, rp2, fv2;
    logic [7:0]  cnt1;
    logic [1:0]  cnt2;
    logic [15:0] fe1, fg1, fe2, fg2;

    int total = 0;
    int bad = 0;
    int pulses2 = 0;

    always #5 clk = ~clk;

    counter_seq_checker #(.WIDTH(16), .ERR_CNT_WIDTH(8), .LOCK_COUNT(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(lk1), .err_pulse(ep1), .restart_pulse(rp1), .err_count(cnt1),
        .first_err_valid(fv1), .first_exp(fe1), .first_got(fg1));

    counter_seq_checker #(.WIDTH(16), .ERR_CNT_WIDTH(2), .LOCK_COUNT(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
        .locked(lk2), .err_pulse(ep2), .restart_pulse(rp2), .err_count(cnt2),
        .first_err_valid(fv2), .first_exp(fe2), .first_got(fg2));

    typedef struct {
        bit r, v, c;
        logic [15:0] d;
        bit lk, ep, rp;
        int cnt;
        bit fv;
        logic [15:0] fe, fg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit v, bit c, logic [15:0] d, bit lk, bit ep, bit rp,
                                int cnt, bit fv, logic [15:0] fe, logic [15:0] fg);
        vec_t t;
        t.r = r; t.v = v; t.c = c; t.d = d; t.lk = lk; t.ep = ep; t.rp = rp;
        t.cnt = cnt; t.fv = fv; t.fe = fe; t.fg = fg;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit c, input logic [15:0] d);
        rst = r; in_valid = v; clear = c; in_data = d;
        @(posedge clk);
        #1;
        if (ep2) pulses2++;
    endtask

    // reference model: run length of consecutive in-sequence samples and a locked flag
    localparam int LC = 4;
    bit          m_have, m_lk, m_ep, m_rp, m_fv;
    int          m_run, m_cnt;
    logic [15:0] m_prev, m_fe, m_fg;

    task automatic model(input bit r, input bit v, input bit c, input logic [15:0] d);
        m_ep = 0; m_rp = 0;
        if (r) begin
            m_have = 0; m_lk = 0; m_fv = 0; m_run = 0; m_cnt = 0; m_fe = 0; m_fg = 0; m_prev = 0;
            return;
        end
        if (c) begin m_cnt = 0; m_fv = 0; m_fe = 0; m_fg = 0; end
        if (!v) return;
        if (!m_have) begin
            m_have = 1; m_run = 1; m_lk = (LC <= 1);
        end else if (d == 16'(m_prev + 1)) begin
            m_run++;
            if (m_run >= LC) m_lk = 1;
        end else begin
            if (m_lk) begin
                if (d == 0) m_rp = 1;
                else begin
                    m_ep = 1;
                    if (m_cnt < 255) m_cnt++;
                    if (!m_fv) begin m_fv = 1; m_fe = 16'(m_prev + 1); m_fg = d; end
                end
            end
            m_run = 1;
            m_lk = (LC <= 1);
        end
        m_prev = d;
    endtask

    initial begin
        logic [15:0] nxt, d;
        bit r, v, c;
        int k;

        // reset / basic lock
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0005, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0006, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,0,0,16'h1234, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0007, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0008, 1,0,0,0,0,16'h0,16'h0));
        // wrap through all-ones
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'hFFFA, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'hFFFB, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'hFFFC, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'hFFFD, 1,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'hFFFE, 1,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'hFFFF, 1,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0000, 1,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0001, 1,0,0,0,0,16'h0,16'h0));
        // restart
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h000D, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h000E, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h000F, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0010, 1,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0000, 0,0,1,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,0,0,16'h0000, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0001, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0002, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0003, 1,0,0,0,0,16'h0,16'h0));
        // two errors, first pair captured
        tbl.push_back(mk(1,0,0,16'h0000, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h001D, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h001E, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h001F, 0,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0020, 1,0,0,0,0,16'h0,16'h0));
        tbl.push_back(mk(0,1,0,16'h0025, 0,1,0,1,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,0,0,16'h0000, 0,0,0,1,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,1,0,16'h0026, 0,0,0,1,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,1,0,16'h0027, 0,0,0,1,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,1,0,16'h0028, 1,0,0,1,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,1,0,16'h0099, 0,1,0,2,1,16'h0021,16'h0025));
        // clear together with an error
        tbl.push_back(mk(0,1,0,16'h002D, 0,0,0,2,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,1,0,16'h002E, 0,0,0,2,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,1,0,16'h002F, 0,0,0,2,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,1,0,16'h0030, 1,0,0,2,1,16'h0021,16'h0025));
        tbl.push_back(mk(0,1,1,16'h0050, 0,1,0,1,1,16'h0031,16'h0050));
        tbl.push_back(mk(0,0,1,16'h0000, 0,0,0,0,0,16'h0,16'h0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].d);
            chk($sformatf("tbl%0d.locked", i), 32'(lk1), 32'(tbl[i].lk));
            chk($sformatf("tbl%0d.err_pulse", i), 32'(ep1), 32'(tbl[i].ep));
            chk($sformatf("tbl%0d.restart_pulse", i), 32'(rp1), 32'(tbl[i].rp));
            chk($sformatf("tbl%0d.err_count", i), 32'(cnt1), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.first_err_valid", i), 32'(fv1), 32'(tbl[i].fv));
            chk($sformatf("tbl%0d.first_exp", i), 32'(fe1), 32'(tbl[i].fe));
            chk($sformatf("tbl%0d.first_got", i), 32'(fg1), 32'(tbl[i].fg));
        end

        // saturation on the 2-bit counter instance
        drive(1, 0, 0, 16'h0);
        pulses2 = 0;
        for (int e = 0; e < 5; e++) begin
            for (int j = 0; j < 4; j++) drive(0, 1, 0, 16'(100 + 20 * e + j));
            chk($sformatf("sat%0d.locked", e), 32'(lk2), 32'd1);
            drive(0, 1, 0, 16'(110 + 20 * e));
            chk($sformatf("sat%0d.err_pulse", e), 32'(ep2), 32'd1);
        end
        chk("sat.pulses", 32'(pulses2), 32'd5);
        chk("sat.err_count", 32'(cnt2), 32'd3);
        chk("sat.first_exp", 32'(fe2), 32'd104);
        chk("sat.first_got", 32'(fg2), 32'd110);

        // reset mid-stream wins over valid and clear
        drive(1, 1, 1, 16'h0005);
        chk("rst.locked", 32'(lk2), 32'd0);
        chk("rst.err_pulse", 32'(ep2), 32'd0);
        chk("rst.restart_pulse", 32'(rp2), 32'd0);
        chk("rst.err_count", 32'(cnt2), 32'd0);
        chk("rst.first", 32'({fv2, fe2, fg2}), 32'd0);
        for (int j = 0; j < 3; j++) drive(0, 1, 0, 16'(7 + j));
        chk("relock.early", 32'(lk2), 32'd0);
        drive(0, 1, 0, 16'd10);
        chk("relock.locked", 32'(lk2), 32'd1);

        // random stream against the model
        model(1, 0, 0, 16'h0);
        drive(1, 0, 0, 16'h0);
        nxt = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 499) == 0;
            v = $urandom_range(0, 3) != 0;
            c = $urandom_range(0, 49) == 0;
            k = $urandom_range(0, 99);
            d = k < 85 ? nxt : k < 90 ? 16'h0 : k < 93 ? 16'hFFFD : 16'($urandom);
            if (v) nxt = d + 16'd1;
            model(r, v, c, d);
            drive(r, v, c, d);
            chk("rnd.locked", 32'(lk1), 32'(m_lk));
            chk("rnd.err_pulse", 32'(ep1), 32'(m_ep));
            chk("rnd.restart_pulse", 32'(rp1), 32'(m_rp));
            chk("rnd.err_count", 32'(cnt1), 32'(m_cnt));
            chk("rnd.first_err_valid", 32'(fv1), 32'(m_fv));
            chk("rnd.first_exp", 32'(fe1), 32'(m_fe));
            chk("rnd.first_got", 32'(fg1), 32'(m_fg));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
